// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and helpers for the pending priority encoder.
package pending_prio_pkg;

    // Selection modes for the RR_MODE parameter.
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_pick.sv
// Combinational highest-set-bit encoder with an any-bit flag.
module prio_pick
    import pending_prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Registered pending-request encoder: captures request pulses into a
// pending register and offers one index at a time over valid/ready,
// using either fixed (highest index) or round-robin selection.
module pending_priority_encoder
    import pending_prio_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = PRIO_FIXED,
    localparam int W      = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic         load;
    logic [N-1:0] cand;
    logic         has_pick;
    logic [W-1:0] pick;
    logic [N-1:0] sel;
    logic [N-1:0] pending_next;
    logic         ovf_next;

    // Slot load decision, candidate set, and pending/overflow next state.
    always_comb begin
        load = !out_valid || out_ready;
        cand = pending | req_in;
        sel  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel[i] = load && has_pick && (pick == W'(i));
        end
        pending_next = cand & ~sel;
        // A request only overflows if it hits a pending bit that is not
        // being moved into the slot on this same edge.
        ovf_next = |(req_in & pending & ~sel);
    end

    if (RR_MODE == PRIO_FIXED) begin : g_fixed

        prio_pick #(
            .N(N),
            .W(W)
        ) u_pick (
            .vec(cand),
            .idx(pick),
            .any(has_pick)
        );

    end else begin : g_rr

        logic [W-1:0] ptr;
        logic [N-1:0] rev_all;
        logic [N-1:0] rev_masked;
        logic [W-1:0] j_all;
        logic [W-1:0] j_masked;
        logic         any_all;
        logic         any_masked;

        // Bit-reverse the candidates so highest-set-bit finds the lowest
        // index; the masked copy keeps only indices above ptr so the scan
        // resumes after the last grant and wraps via the unmasked copy.
        always_comb begin
            rev_all    = '0;
            rev_masked = '0;
            for (int unsigned i = 0; i < N; i++) begin
                rev_all[i]    = cand[N-1-i];
                rev_masked[i] = cand[N-1-i] && ((N - 1 - i) > 32'(ptr));
            end
        end

        prio_pick #(
            .N(N),
            .W(W)
        ) u_pick_masked (
            .vec(rev_masked),
            .idx(j_masked),
            .any(any_masked)
        );

        prio_pick #(
            .N(N),
            .W(W)
        ) u_pick_all (
            .vec(rev_all),
            .idx(j_all),
            .any(any_all)
        );

        // Map the reversed position back to a request index.
        always_comb begin
            has_pick = any_all;
            pick     = W'(N - 1) - (any_masked ? j_masked : j_all);
        end

        // Round-robin pointer follows the last index loaded into the slot.
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr <= W'(N - 1);
            end else if (load && has_pick) begin
                ptr <= pick;
            end
        end

    end

    // Pending register, output slot and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= ovf_next;
            if (load) begin
                out_valid <= has_pick;
                if (has_pick) begin
                    out_idx <= pick;
                end
            end
        end
    end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Scoreboard bench: expected issue indices are queued as requests are
// driven and popped whenever an instance completes a valid/ready transfer.
module tb_pending_priority_encoder;
    import pending_prio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority instance, N=8.
    logic       rst;
    logic [7:0] req8;
    logic [2:0] idx8;
    logic       v8;
    logic       rdy8;
    logic [7:0] pend8;
    logic       ovf8;

    // Round-robin instance, N=5.
    logic       rst_rr;
    logic [4:0] req5;
    logic [2:0] idx5;
    logic       v5;
    logic       rdy5;
    logic [4:0] pend5;
    logic       ovf5;

    int checks = 0;
    int errors = 0;
    int unsigned q8[$];
    int unsigned q5[$];

    pending_priority_encoder #(
        .N(8),
        .RR_MODE(PRIO_FIXED)
    ) dut_fixed (
        .clk(clk),
        .rst(rst),
        .req_in(req8),
        .out_idx(idx8),
        .out_valid(v8),
        .out_ready(rdy8),
        .pending(pend8),
        .overflow(ovf8)
    );

    pending_priority_encoder #(
        .N(5),
        .RR_MODE(PRIO_RR)
    ) dut_rr (
        .clk(clk),
        .rst(rst_rr),
        .req_in(req5),
        .out_idx(idx5),
        .out_valid(v5),
        .out_ready(rdy5),
        .pending(pend5),
        .overflow(ovf5)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitors: a transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && v8 && rdy8) begin
            check_eq("fixed_issue_expected", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) check_eq("fixed_issue_idx", 32'(idx8), q8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst_rr && v5 && rdy5) begin
            check_eq("rr_issue_expected", 32'(q5.size() > 0), 32'd1);
            if (q5.size() > 0) check_eq("rr_issue_idx", 32'(idx5), q5.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        rst_rr = 1'b1;
        req8   = 8'hFF;
        req5   = 5'h1F;
        rdy8   = 1'b1;
        rdy5   = 1'b1;

        // 1. Reset with requests asserted; nothing may be captured.
        tick();
        tick();
        rst  = 1'b0;
        req8 = 8'h00;
        req5 = 5'h00;
        check_eq("rst_pending", 32'(pend8), 32'h00);
        check_eq("rst_valid", 32'(v8), 32'd0);
        check_eq("rst_overflow", 32'(ovf8), 32'd0);
        check_eq("rst_idx", 32'(idx8), 32'd0);
        check_eq("rst_rr_valid", 32'(v5), 32'd0);
        check_eq("rst_rr_overflow", 32'(ovf5), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_idle_valid", 32'(v8), 32'd0);
        end

        // 2. Single request: one-cycle latency, exactly one issue.
        req8 = 8'b0001_0000;
        q8.push_back(4);
        tick();
        req8 = 8'h00;
        check_eq("single_valid", 32'(v8), 32'd1);
        check_eq("single_idx", 32'(idx8), 32'd4);
        tick();
        check_eq("single_after_valid", 32'(v8), 32'd0);
        check_eq("single_after_pending", 32'(pend8), 32'h00);

        // 3. Two simultaneous requests issue highest first.
        req8 = 8'b0100_0001;
        q8.push_back(6);
        q8.push_back(0);
        tick();
        req8 = 8'h00;
        check_eq("fixed_first_idx", 32'(idx8), 32'd6);
        check_eq("fixed_first_pending", 32'(pend8), 32'h01);
        tick();
        check_eq("fixed_second_idx", 32'(idx8), 32'd0);
        check_eq("fixed_second_pending", 32'(pend8), 32'h00);
        tick();
        check_eq("fixed_done_valid", 32'(v8), 32'd0);

        // 4. Backpressure: slot held, same-bit request queues silently.
        rdy8 = 1'b0;
        req8 = 8'h80;
        q8.push_back(7);
        tick();
        req8 = 8'h00;
        check_eq("bp_valid", 32'(v8), 32'd1);
        check_eq("bp_idx", 32'(idx8), 32'd7);
        check_eq("bp_pending0", 32'(pend8), 32'h00);
        tick();
        check_eq("bp_hold_idx", 32'(idx8), 32'd7);
        req8 = 8'h80;
        q8.push_back(7);
        tick();
        req8 = 8'h00;
        check_eq("bp_same_pending", 32'(pend8), 32'h80);
        check_eq("bp_same_overflow", 32'(ovf8), 32'd0);
        check_eq("bp_same_idx", 32'(idx8), 32'd7);
        req8 = 8'h01;
        q8.push_back(0);
        tick();
        req8 = 8'h00;
        check_eq("bp_pending81", 32'(pend8), 32'h81);
        check_eq("bp_still_idx", 32'(idx8), 32'd7);
        check_eq("bp_still_valid", 32'(v8), 32'd1);
        rdy8 = 1'b1;
        tick();
        check_eq("bp_drain1_idx", 32'(idx8), 32'd7);
        check_eq("bp_drain1_pending", 32'(pend8), 32'h01);
        tick();
        check_eq("bp_drain2_idx", 32'(idx8), 32'd0);
        check_eq("bp_drain2_pending", 32'(pend8), 32'h00);
        tick();
        check_eq("bp_drain_valid", 32'(v8), 32'd0);

        // 5. Overflow on a third pulse to the same bit under backpressure.
        rdy8 = 1'b0;
        req8 = 8'h08;
        q8.push_back(3);
        tick();
        req8 = 8'h00;
        check_eq("ovf_slot_idx", 32'(idx8), 32'd3);
        check_eq("ovf_slot_pending", 32'(pend8), 32'h00);
        check_eq("ovf_first", 32'(ovf8), 32'd0);
        tick();
        req8 = 8'h08;
        q8.push_back(3);
        tick();
        req8 = 8'h00;
        check_eq("ovf_second_pending", 32'(pend8), 32'h08);
        check_eq("ovf_second", 32'(ovf8), 32'd0);
        req8 = 8'h08;
        tick();
        req8 = 8'h00;
        check_eq("ovf_third", 32'(ovf8), 32'd1);
        check_eq("ovf_third_pending", 32'(pend8), 32'h08);
        tick();
        check_eq("ovf_pulse_clear", 32'(ovf8), 32'd0);
        rdy8 = 1'b1;
        tick();
        check_eq("ovf_drain_idx", 32'(idx8), 32'd3);
        tick();
        check_eq("ovf_drain_valid", 32'(v8), 32'd0);
        check_eq("fixed_queue_empty", 32'(q8.size()), 32'd0);

        // 6. Round-robin over N=5 with all requests held.
        rst_rr = 1'b0;
        tick();
        check_eq("rr_idle_valid", 32'(v5), 32'd0);
        check_eq("rr_idle_pending", 32'(pend5), 32'h00);
        req5 = 5'b11111;
        q5.push_back(0);
        q5.push_back(1);
        q5.push_back(2);
        q5.push_back(3);
        q5.push_back(4);
        q5.push_back(0);
        q5.push_back(1);
        for (int i = 0; i < 7; i++) tick();
        check_eq("rr_last_idx", 32'(idx5), 32'd1);
        @(negedge clk);
        #1;
        rst_rr = 1'b1;
        req5   = 5'h00;
        tick();
        rst_rr = 1'b0;
        check_eq("rr_rst_valid", 32'(v5), 32'd0);
        check_eq("rr_rst_pending", 32'(pend5), 32'h00);
        tick();
        check_eq("rr_post_rst_valid", 32'(v5), 32'd0);
        check_eq("rr_queue_empty", 32'(q5.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
